// File: rtl/axi_write_master.sv
// axi_write_master: single-outstanding AXI3 write burst issuer (AW, then W beats, then B).
// Optional B-wait timeout enabled by defining WRITE_MASTER_TIMEOUT_EN.
module axi_write_master #(
    parameter int buswidth       = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_id,
    input  logic [31:0]         req_addr,
    input  logic [3:0]          req_len,
    input  logic [2:0]          req_size,
    input  logic [1:0]          req_burst,
    input  logic [buswidth-1:0] wr_data,
    input  logic [3:0]          wr_strb,
    input  logic                wr_data_valid,
    output logic                wr_data_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic [3:0]          AWID,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [1:0]          AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [3:0]          WID,
    output logic [buswidth-1:0] WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t     state, next;
    logic [3:0] cnt;
    logic       xfer, last, timeout;

`ifdef WRITE_MASTER_TIMEOUT_EN
    logic [31:0] tcnt;
    assign timeout = state == RESP && !BVALID && tcnt == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) tcnt <= '0;
        else          tcnt <= state == RESP ? tcnt + 32'd1 : '0;
`else
    assign timeout = 1'b0 && TIMEOUT_CYCLES != 0;
`endif

    assign xfer          = state == DATA && wr_data_valid && WREADY;
    assign last          = cnt == AWLEN;
    assign req_ready     = state == IDLE;
    assign AWVALID       = state == ADDR;
    assign WVALID        = state == DATA && wr_data_valid;
    assign wr_data_ready = state == DATA && WREADY;
    assign WDATA         = state == DATA ? wr_data : '0;
    assign WSTRB         = state == DATA ? wr_strb : 4'd0;
    assign WLAST         = state == DATA && last;
    assign WID           = AWID;
    assign BREADY        = state == RESP;
    assign AWLOCK        = 2'd0;
    assign AWCACHE       = 4'd0;
    assign AWPROT        = 3'd0;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req_valid ? ADDR : IDLE;
            ADDR:    next = AWREADY ? DATA : ADDR;
            DATA:    next = xfer && last ? RESP : DATA;
            RESP:    next = BVALID || timeout ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) state <= IDLE;
        else          state <= next;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            AWID      <= '0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWSIZE    <= '0;
            AWBURST   <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            if (state == IDLE && req_valid) begin
                AWID    <= req_id;
                AWADDR  <= req_addr;
                AWLEN   <= req_len;
                AWSIZE  <= req_size;
                AWBURST <= req_burst;
                cnt     <= '0;
            end else if (xfer) begin
                cnt <= cnt + 4'd1;
            end
            done <= state == RESP && (BVALID || timeout);
            // a response carrying a foreign ID is reported as SLVERR
            if (state == RESP && BVALID) done_resp <= BID == AWID ? BRESP : 2'b10;
            else if (timeout)            done_resp <= 2'b10;
        end
    end
endmodule

// File: tb/tb_axi_write_master.sv
// tb_axi_write_master: table-driven bursts plus stall, reset and B-wait sequences.
module tb_axi_write_master;
    logic        ACLK = 1'b0, ARESETn = 1'b0;
    logic        req_valid, req_ready;
    logic [3:0]  req_id, req_len;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_data_valid, wr_data_ready, done;
    logic [1:0]  done_resp;
    logic [3:0]  AWID, AWLEN, AWCACHE, WID, WSTRB, BID;
    logic [31:0] AWADDR, WDATA;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST, AWLOCK, BRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    int checks = 0, errors = 0;
    logic [3:0] vpat = 4'b1001;

    always #5 ACLK = ~ACLK;

    axi_write_master #(.buswidth(32), .TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .done(done),
        .done_resp(done_resp), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP),
        .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic [1:0]  exp_resp;
        int          mode;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // issue request, complete AW, stream len+1 beats; ends in the first RESP cycle
    task automatic do_req_data(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int mode);
        int b;
        logic [31:0] d;
        logic [3:0] s;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_id = id; req_addr = addr; req_len = len; req_size = size; req_burst = burst;
        tick;
        req_valid = 0; req_id = 4'hF; req_addr = 32'hDEAD_BEEF; req_len = 4'h9; req_size = 3'd0; req_burst = 2'b11;
        wr_data_valid = 1; WREADY = 1; BVALID = 1;
        #1;
        chk("awvalid", AWVALID, 1);
        chk("awaddr", AWADDR, addr);
        chk("awlen", AWLEN, len);
        chk("awid", AWID, id);
        chk("awsize", AWSIZE, size);
        chk("awburst", AWBURST, burst);
        chk("awconst", {AWLOCK, AWCACHE, AWPROT}, 0);
        chk("wvalid_addr", WVALID, 0);
        chk("bready_addr", BREADY, 0);
        chk("req_ready_busy", req_ready, 0);
        BVALID = 0;
        tick;
        chk("awvalid_hold", AWVALID, 1);
        AWREADY = 1;
        tick;
        AWREADY = 0;
        chk("awvalid_after", AWVALID, 0);
        b = 0;
        for (int c = 0; c < 200 && b <= int'(len); c++) begin
            wr_data_valid = mode != 0 ? vpat[c % 4] : 1'b1;
            WREADY = mode != 0 ? !(c == 4 || c == 5) : 1'b1;
            d = 32'hA500_0000 | (b << 8) | 32'(id);
            s = ~4'(b);
            wr_data = d; wr_strb = s;
            #1;
            chk("wvalid", WVALID, wr_data_valid);
            if (wr_data_valid) begin
                chk("wdata", WDATA, d);
                chk("wstrb", WSTRB, s);
                chk("wlast", WLAST, b == int'(len));
                chk("wid", WID, id);
            end
            chk("wr_data_ready", wr_data_ready, WREADY);
            if (wr_data_valid && WREADY) b++;
            tick;
        end
        wr_data_valid = 0; WREADY = 0;
        #1;
        chk("beats", b, int'(len) + 1);
        chk("bready_resp", BREADY, 1);
        chk("wvalid_resp", WVALID, 0);
        chk("wdata_resp", WDATA, 0);
        chk("done_resp_phase", done, 0);
    endtask

    task automatic do_b(input logic [3:0] bid, input logic [1:0] bresp, input logic [1:0] exp);
        BID = bid; BRESP = bresp; BVALID = 1;
        #1;
        chk("bready_b", BREADY, 1);
        tick;
        BVALID = 0;
        chk("done", done, 1);
        chk("done_resp", done_resp, exp);
        chk("req_ready_done", req_ready, 1);
        chk("bready_idle", BREADY, 0);
        tick;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_id = 0; req_addr = 0; req_len = 0; req_size = 0; req_burst = 0;
        wr_data = 0; wr_strb = 0; wr_data_valid = 0; AWREADY = 0; WREADY = 0;
        BID = 0; BRESP = 0; BVALID = 0;
        vt[0] = '{4'd3, 32'h100, 4'd3,  3'd2, 2'b01, 4'd3, 2'b00, 2'b00, 0};
        vt[1] = '{4'd7, 32'h200, 4'd0,  3'd2, 2'b01, 4'd7, 2'b01, 2'b01, 0};
        vt[2] = '{4'd3, 32'h300, 4'd5,  3'd2, 2'b01, 4'd3, 2'b00, 2'b00, 1};
        vt[3] = '{4'd3, 32'h400, 4'd2,  3'd1, 2'b10, 4'd5, 2'b00, 2'b10, 0};
        vt[4] = '{4'd9, 32'h500, 4'd15, 3'd0, 2'b00, 4'd9, 2'b11, 2'b11, 0};
        vt[5] = '{4'd2, 32'h600, 4'd1,  3'd7, 2'b01, 4'd2, 2'b00, 2'b00, 0};

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_done", done, 0);
        chk("rst_done_resp", done_resp, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_awid", {AWID, AWLEN, AWSIZE, AWBURST}, 0);
        ARESETn = 1;
        tick;
        chk("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_req_data(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].mode);
            do_b(vt[i].bid, vt[i].bresp, vt[i].exp_resp);
        end

        // reset mid-burst after 2 of 4 beats
        req_valid = 1; req_id = 4'd4; req_addr = 32'h700; req_len = 4'd3; req_size = 3'd2; req_burst = 2'b01;
        tick;
        req_valid = 0;
        AWREADY = 1;
        tick;
        AWREADY = 0; wr_data_valid = 1; WREADY = 1; wr_data = 32'h1234_5678; wr_strb = 4'hF;
        tick;
        tick;
        chk("mid_wvalid", WVALID, 1);
        ARESETn = 0;
        #1;
        chk("rst_mid_awvalid", AWVALID, 0);
        chk("rst_mid_wvalid", WVALID, 0);
        chk("rst_mid_bready", BREADY, 0);
        chk("rst_mid_wr_ready", wr_data_ready, 0);
        tick;
        ARESETn = 1; wr_data_valid = 0; WREADY = 0;
        tick;
        chk("rst_mid_no_done", done, 0);
        chk("rst_mid_idle", req_ready, 1);
        do_req_data(4'd3, 32'h100, 4'd3, 3'd2, 2'b01, 0);
        do_b(4'd3, 2'b00, 2'b00);

        do_req_data(4'd6, 32'h800, 4'd1, 3'd2, 2'b01, 0);
`ifdef WRITE_MASTER_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            chk("to_bready", BREADY, 1);
            chk("to_no_done", done, 0);
            tick;
        end
        chk("to_done", done, 1);
        chk("to_done_resp", done_resp, 2'b10);
        chk("to_bready_after", BREADY, 0);
        BVALID = 1; BID = 4'd6; BRESP = 2'b00;
        #1;
        chk("to_late_bready", BREADY, 0);
        tick;
        BVALID = 0;
        chk("to_late_no_done", done, 0);
        chk("to_idle", req_ready, 1);
`else
        repeat (20) tick;
        chk("wait_bready", BREADY, 1);
        chk("wait_no_done", done, 0);
        do_b(4'd6, 2'b00, 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_write_master.md
# axi_write_master

Issuing side of the AXI3 write path: accepts a single write-burst request and a beat stream from a local requester, drives the AW, W and B channels toward the write slave, and reports completion with the response code. One burst is outstanding at a time, with no AW/W interleaving. The block sits directly upstream of the write slave and feeds its AW/W inputs while consuming its B outputs.

## Interface
Parameters:
- buswidth, 32, WDATA/wr_data width; must be 32 (WSTRB fixed at 4 bits)
- TIMEOUT_CYCLES, 256, B-wait limit; only used under the timeout macro

Ports:
- ACLK  in  1  clock; all logic is on the rising edge
- ARESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  block idle, request accepted this cycle if req_valid
- req_id  in  4  transaction ID
- req_addr  in  32  start address
- req_len  in  4  beats minus one (0..15)
- req_size  in  3  bytes per beat, log2 (0..2)
- req_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- wr_data  in  buswidth  beat data
- wr_strb  in  4  beat byte strobes
- wr_data_valid  in  1  beat present
- wr_data_ready  out  1  beat consumed this cycle
- done  out  1  one-cycle completion pulse
- done_resp  out  2  response for the completed burst; valid with done
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  4/32/4/3/2  registered copies of the request
- AWLOCK/AWCACHE/AWPROT  out  2/4/3  constant 0
- AWVALID  out  1 ; AWREADY  in  1
- WID  out  4 ; WDATA  out  buswidth ; WSTRB  out  4 ; WLAST  out  1 ; WVALID  out  1 ; WREADY  in  1
- BID  in  4 ; BRESP  in  2 ; BVALID  in  1 ; BREADY  out  1

## Operation
States:
- IDLE: req_ready=1. On req_valid, latch id/addr/len/size/burst, clear beat counter, and go to ADDR.
- ADDR: AWVALID=1 with the latched fields held stable. On AWREADY, go to DATA.
- DATA: WVALID=wr_data_valid; WDATA=wr_data; WSTRB=wr_strb; WID=latched id; wr_data_ready=WREADY. These are combinational pass-throughs in this state only.
  - A beat transfers when WVALID&&WREADY. The 4-bit beat counter then increments.
  - WLAST=1 iff counter==latched len.
  - A transfer with WLAST set goes to RESP.
- RESP: BREADY=1. On BVALID:
  - done=1 next cycle.
  - done_resp=BRESP if BID==latched id, else 2'b10 (SLVERR).
  - Go to IDLE.
- done is registered, so it is high in the first IDLE cycle.

Outside their owning state, AWVALID, WVALID, WLAST, wr_data_ready and BREADY are 0. WDATA and WSTRB are 0 outside DATA.

Arithmetic and boundary rules:
- The beat counter is compared at 4 bits and never wraps within a burst; max 16 beats.
- req_len=0: the first beat carries WLAST.
- req_size>2 is out of contract and is passed through unchanged.
- wr_data_valid low in DATA: WVALID low and the counter holds. Stalls of any length are legal.
- BVALID in ADDR or DATA is ignored (BREADY=0).
- A new req_valid is accepted in the same cycle done is high, because the block is already in IDLE.

Reset:
- Asserting ARESETn immediately (asynchronously) forces IDLE.
- AWVALID=WVALID=BREADY=done=0, done_resp=00, AW* outputs 0, counter 0.
- req_ready=1 from the first clock edge after release.
- A reset mid-burst abandons the burst with no done pulse.

## Timing
- Request accepted at edge N → AWVALID high in cycle N+1.
- AW handshake at edge M → first WVALID possible in cycle M+1.
- One beat per cycle when wr_data_valid and WREADY are both high continuously.
- Last W handshake at edge L → BREADY high in cycle L+1.
- B handshake at edge R → done high in cycle R+1, for exactly one cycle.
- Minimum burst latency, request to done with zero-wait slave: len+5 cycles.

## Configuration
- WRITE_MASTER_TIMEOUT_EN defined: RESP runs a counter, cleared on entry.
  - If BVALID is not seen after TIMEOUT_CYCLES cycles in RESP, go to IDLE with done=1 and done_resp=2'b10.
  - A late BVALID arriving in IDLE is ignored (BREADY=0).
- Undefined: no counter; RESP waits for BVALID indefinitely.

## Test plan
- INCR burst, id=3, addr=0x100, len=3, size=2, slave always ready → AWADDR=0x100, AWLEN=3; 4 consecutive W beats, WLAST on beat 4 only; BRESP=00 → done=1, done_resp=00 in cycle R+1.
- len=0 single beat → WLAST=1 on the first and only beat; counter never exceeds 0.
- wr_data_valid toggling 1,0,0,1 and WREADY held low 2 cycles mid-burst → beat count still exactly len+1; WDATA/WSTRB unchanged while WVALID&&!WREADY.
- BID=5 returned for latched id=3 with BRESP=00 → done_resp=10.
- ARESETn pulsed low during DATA after 2 of 4 beats → AWVALID/WVALID/BREADY drop immediately; no done; a new request afterwards completes normally.
- With WRITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, BVALID never asserted → done=1, done_resp=10 after 8 RESP cycles; BREADY=0 afterwards.
